// File: rtl/input_edge_capture_if.sv
// Bus-side bundle for input_edge_capture: filtered input, controls and capture results.
// Latency: none (wires only).
// Backpressure: none; results are levels/sticky flags that the consumer acknowledges with clr.
//
// Signals (direction seen from the capture block, i.e. the slave modport):
//   in        in   filtered, already-synchronised input level
//   en        in   capture enable
//   edge_sel  in   00 none, 01 rising, 10 falling, 11 both
//   clr       in   one-cycle pulse, clears pend/ovr
//   cnt_clr   in   one-cycle pulse, clears cnt_out/cnt_sat
//   presc     in   timestamp prescaler (only with INPUT_EDGE_CAPTURE_PRESCALER_EN)
//   cnt_out   out  selected-edge count, saturating
//   cnt_sat   out  sticky saturation flag
//   ts_out    out  timestamp of most recent event
//   pend      out  event pending
//   ovr       out  sticky overrun
//   irq       out  pend & en
interface input_edge_capture_if #(
  parameter int CNT_WIDTH = 16,
  parameter int TS_WIDTH  = 16
);
  logic                 in;
  logic                 en;
  logic [1:0]           edge_sel;
  logic                 clr;
  logic                 cnt_clr;
`ifdef INPUT_EDGE_CAPTURE_PRESCALER_EN
  logic [7:0]           presc;
`endif
  logic [CNT_WIDTH-1:0] cnt_out;
  logic                 cnt_sat;
  logic [TS_WIDTH-1:0]  ts_out;
  logic                 pend;
  logic                 ovr;
  logic                 irq;

`ifdef INPUT_EDGE_CAPTURE_PRESCALER_EN
  modport master (
    output in, en, edge_sel, clr, cnt_clr, presc,
    input  cnt_out, cnt_sat, ts_out, pend, ovr, irq
  );
  modport slave (
    input  in, en, edge_sel, clr, cnt_clr, presc,
    output cnt_out, cnt_sat, ts_out, pend, ovr, irq
  );
`else
  modport master (
    output in, en, edge_sel, clr, cnt_clr,
    input  cnt_out, cnt_sat, ts_out, pend, ovr, irq
  );
  modport slave (
    input  in, en, edge_sel, clr, cnt_clr,
    output cnt_out, cnt_sat, ts_out, pend, ovr, irq
  );
`endif
endinterface

// File: rtl/input_edge_capture.sv
// Edge detector with event counter, timestamp capture and pending/overrun interrupt.
// Latency: input change at posedge N is judged during the following cycle; results update at N+1.
// Backpressure: none; a new event while pend=1 is still captured and flags ovr.
//
// Ports: clk (system clock), rst (synchronous, active-high), bus (input_edge_capture_if.slave,
// carrying in/en/edge_sel/clr/cnt_clr[/presc] and cnt_out/cnt_sat/ts_out/pend/ovr/irq).
// Optional feature: define INPUT_EDGE_CAPTURE_PRESCALER_EN to add the 8-bit timestamp prescaler
// (bus.presc); without it the timestamp counter advances every enabled cycle.
module input_edge_capture #(
  parameter int CNT_WIDTH  = 16,
  parameter int TS_WIDTH   = 16,
  parameter bit DEFAULT_IN = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  input_edge_capture_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Registered copy of the input; must reset to the upstream filter's idle level so the
  // first cycle out of reset does not look like an edge.
  logic                 in_q;
  logic                 rise;
  logic                 fall;
  logic                 ev;

  logic [TS_WIDTH-1:0]  ts_cnt;
  logic                 ts_tick;

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_base;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 sat_q;
  logic                 sat_base;
  logic                 sat_nxt;
  logic [TS_WIDTH-1:0]  ts_q;
  logic                 pend_q;
  logic                 pend_base;
  logic                 pend_nxt;
  logic                 ovr_q;
  logic                 ovr_base;
  logic                 ovr_nxt;

  // Edge detection uses the live edge_sel, so a select change judges the in-flight edge too.
  always_comb begin
    rise = bus.in & ~in_q;
    fall = ~bus.in & in_q;
    ev   = bus.en & ((bus.edge_sel[0] & rise) | (bus.edge_sel[1] & fall));
  end

`ifdef INPUT_EDGE_CAPTURE_PRESCALER_EN
  // Divider counts 0..presc and ticks on the last count. presc_q tracks the port every cycle
  // (even while disabled) so only a change during enabled operation restarts the divider.
  logic [7:0] div_cnt;
  logic [7:0] presc_q;
  logic       presc_chg;

  always_comb begin
    presc_chg = (bus.presc != presc_q);
    ts_tick   = !presc_chg && (div_cnt == presc_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      presc_q <= '0;
    end else begin
      presc_q <= bus.presc;
      if (!bus.en || presc_chg || ts_tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end
`else
  always_comb begin
    ts_tick = 1'b1;
  end
`endif

  // Clears are applied first and the event on top, so an event in the same cycle as a clear
  // wins: cnt_clr+ev leaves a count of one, clr+ev leaves pend set and ovr clear.
  always_comb begin
    cnt_base  = bus.cnt_clr ? '0 : cnt_q;
    sat_base  = bus.cnt_clr ? 1'b0 : sat_q;
    pend_base = bus.clr ? 1'b0 : pend_q;
    ovr_base  = bus.clr ? 1'b0 : ovr_q;

    cnt_nxt   = cnt_base;
    sat_nxt   = sat_base;
    pend_nxt  = pend_base;
    ovr_nxt   = ovr_base;

    if (ev) begin
      if (cnt_base != CNT_MAX) begin
        cnt_nxt = cnt_base + CNT_WIDTH'(1);
      end
      sat_nxt  = sat_base | (cnt_nxt == CNT_MAX);
      pend_nxt = 1'b1;
      ovr_nxt  = ovr_base | pend_base;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q   <= DEFAULT_IN;
      ts_cnt <= '0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
      ts_q   <= '0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      in_q <= bus.in;

      if (!bus.en) begin
        ts_cnt <= '0;
      end else if (ts_tick) begin
        ts_cnt <= ts_cnt + TS_WIDTH'(1);
      end

      // Capture the pre-increment counter value of the cycle the event was seen in.
      if (ev) begin
        ts_q <= ts_cnt;
      end

      cnt_q  <= cnt_nxt;
      sat_q  <= sat_nxt;
      pend_q <= pend_nxt;
      ovr_q  <= ovr_nxt;
    end
  end

  assign bus.cnt_out = cnt_q;
  assign bus.cnt_sat = sat_q;
  assign bus.ts_out  = ts_q;
  assign bus.pend    = pend_q;
  assign bus.ovr     = ovr_q;
  assign bus.irq     = pend_q & bus.en;

endmodule

// File: tb/tb_input_edge_capture.sv
// Directed bench for input_edge_capture with 4-bit counter and timestamp.
// Inputs change 1 time unit after a rising clock edge; outputs are checked at the same point.
// Expected timestamps depend on whether INPUT_EDGE_CAPTURE_PRESCALER_EN is defined.
module tb_input_edge_capture;

  localparam int CW = 4;
  localparam int TW = 4;

`ifdef INPUT_EDGE_CAPTURE_PRESCALER_EN
  // presc=3: one tick every 4 enabled cycles
  localparam int TS_AT40  = 10;
  localparam int TA       = 63;
  localparam int TB       = 64;
`else
  localparam int TS_AT40  = 8;   // 40 mod 16
  localparam int TA       = 47;
  localparam int TB       = 48;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  input_edge_capture_if #(.CNT_WIDTH(CW), .TS_WIDTH(TW)) bus ();

  input_edge_capture #(
    .CNT_WIDTH (CW),
    .TS_WIDTH  (TW),
    .DEFAULT_IN(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic toggle_step();
    bus.in = ~bus.in;
    step(1);
  endtask

  initial begin
    rst          = 1'b1;
    bus.in       = 1'b1;
    bus.en       = 1'b0;
    bus.edge_sel = 2'b00;
    bus.clr      = 1'b0;
    bus.cnt_clr  = 1'b0;
`ifdef INPUT_EDGE_CAPTURE_PRESCALER_EN
    bus.presc    = 8'd0;
`endif
    step(2);
    rst = 1'b0;
    step(1);

    // reset values
    check("rst_cnt",  bus.cnt_out, 0);
    check("rst_sat",  bus.cnt_sat, 0);
    check("rst_ts",   bus.ts_out,  0);
    check("rst_pend", bus.pend,    0);
    check("rst_ovr",  bus.ovr,     0);
    check("rst_irq",  bus.irq,     0);

    // disabled: toggling gives nothing
    bus.edge_sel = 2'b11;
    bus.in = 1'b0; step(2);
    bus.in = 1'b1; step(2);
    check("dis_cnt",  bus.cnt_out, 0);
    check("dis_pend", bus.pend,    0);

    // rising only, ts_cnt starts at 0 when enabled
    bus.en = 1'b1; bus.edge_sel = 2'b01;
    step(10);
    bus.in = 1'b0; step(10);               // falling, ignored; ts_cnt now 20 mod 16 = 4
    check("rise_fall_ign", bus.pend, 0);
    bus.in = 1'b1; step(1);
    check("rise_cnt",  bus.cnt_out, 1);
    check("rise_pend", bus.pend,    1);
    check("rise_irq",  bus.irq,     1);
    check("rise_ts",   bus.ts_out,  4);
    step(10);
    bus.in = 1'b0; step(10);
    check("rise_single", bus.cnt_out, 1);
    bus.en = 1'b0; step(1);
    check("irq_gated", bus.irq,  0);
    check("pend_hold", bus.pend, 1);

    // both edges without clr, then clr
    bus.en = 1'b1; bus.clr = 1'b1; bus.cnt_clr = 1'b1;
    step(1);                               // ts_cnt=1
    bus.clr = 1'b0; bus.cnt_clr = 1'b0;
    check("clr_pend", bus.pend,    0);
    check("clr_cnt",  bus.cnt_out, 0);
    bus.edge_sel = 2'b11;
    bus.in = 1'b1; step(3);
    bus.in = 1'b0; step(3);
    bus.in = 1'b1; step(1);
    check("both_cnt", bus.cnt_out, 3);
    check("both_ovr", bus.ovr,     1);
    check("both_ts",  bus.ts_out,  7);
    bus.clr = 1'b1; step(1); bus.clr = 1'b0;
    check("clr2_pend", bus.pend,    0);
    check("clr2_ovr",  bus.ovr,     0);
    check("clr2_cnt",  bus.cnt_out, 3);
    check("clr2_irq",  bus.irq,     0);

    // same-cycle clr/cnt_clr with events
    bus.in = 1'b0; step(1);
    check("ev_pend", bus.pend, 1);
    bus.in = 1'b1; bus.clr = 1'b1; step(1); bus.clr = 1'b0;
    check("clrev_pend", bus.pend,    1);
    check("clrev_ovr",  bus.ovr,     0);
    check("clrev_cnt",  bus.cnt_out, 5);
    bus.in = 1'b0; step(1);
    check("ovr_set", bus.ovr, 1);
    bus.in = 1'b1; bus.clr = 1'b1; step(1); bus.clr = 1'b0;
    check("clrev2_ovr", bus.ovr, 0);
    bus.in = 1'b0; bus.cnt_clr = 1'b1; step(1); bus.cnt_clr = 1'b0;
    check("cclrev_cnt", bus.cnt_out, 1);
    check("cclrev_sat", bus.cnt_sat, 0);
    check("cclrev_ovr", bus.ovr,     1);

    // saturation at 15
    bus.cnt_clr = 1'b1; step(1); bus.cnt_clr = 1'b0;
    check("sat_start", bus.cnt_out, 0);
    for (int i = 0; i < 14; i++) toggle_step();
    check("sat14_cnt", bus.cnt_out, 14);
    check("sat14_sat", bus.cnt_sat, 0);
    toggle_step();
    check("sat15_cnt", bus.cnt_out, 15);
    check("sat15_sat", bus.cnt_sat, 1);
    toggle_step();
    toggle_step();
    check("sat17_cnt", bus.cnt_out, 15);
    check("sat17_sat", bus.cnt_sat, 1);

    // disabled: hold, but clears act
    bus.en = 1'b0;
    toggle_step();
    toggle_step();
    check("hold_cnt",  bus.cnt_out, 15);
    check("hold_pend", bus.pend,    1);
    bus.cnt_clr = 1'b1; step(1); bus.cnt_clr = 1'b0;
    check("dcclr_cnt", bus.cnt_out, 0);
    check("dcclr_sat", bus.cnt_sat, 0);
    bus.clr = 1'b1; step(1); bus.clr = 1'b0;
    check("dclr_pend", bus.pend, 0);
    check("dclr_ovr",  bus.ovr,  0);

    // reset mid-operation
    bus.en = 1'b1;
    toggle_step();
    check("pre_rst_cnt", bus.cnt_out, 1);
    rst = 1'b1; bus.in = 1'b0; step(1);
    rst = 1'b0; bus.in = 1'b1;
    check("mrst_cnt",  bus.cnt_out, 0);
    check("mrst_pend", bus.pend,    0);
    check("mrst_ts",   bus.ts_out,  0);
    check("mrst_irq",  bus.irq,     0);
    step(1);                               // in_q reset to 1, so in=1 is not a rise
    check("mrst_noedge", bus.cnt_out, 0);

    // timestamp counting / prescaler / wrap
    bus.en = 1'b0;
`ifdef INPUT_EDGE_CAPTURE_PRESCALER_EN
    bus.presc = 8'd3;
`endif
    step(2);
    bus.en = 1'b1;
    step(40);
    toggle_step();
    check("ts_40", bus.ts_out, TS_AT40);
    step(TA - 41);
    toggle_step();
    check("ts_max", bus.ts_out, 15);
    step(TB - TA - 1);
    toggle_step();
    check("ts_wrap", bus.ts_out, 0);
    check("ts_cnt3", bus.cnt_out, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
